mult_fu: RTL and testbench

//  Pipelined RV32M multiply functional unit: MUL, MULH, MULHSU, MULHU.

---
 rtl/mult_fu.sv | 168 ++++++++++++++++
 tb/tb_mult_fu.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_fu.sv
// Pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU) with done/ack handshake, backpressure and squash.
// Optional performance counters are enabled with the MULT_FU_PERF_CNT_EN macro.
module mult_fu #(
    parameter int XLEN       = 32,
    parameter int NUM_STAGES = 4,
    parameter int TAG_W      = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             squash,
    input  logic             issue_valid,
    input  logic [1:0]       func,
    input  logic [XLEN-1:0]  opa,
    input  logic [XLEN-1:0]  opb,
    input  logic [TAG_W-1:0] rob_tag,
    input  logic             ack,
    output logic             ready,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_rob_tag
`ifdef MULT_FU_PERF_CNT_EN
    ,
    output logic [31:0]      perf_completions,
    output logic [31:0]      perf_stall_cycles
`endif
);

    localparam int CW    = XLEN / NUM_STAGES;
    localparam int PW    = 2 * XLEN;
    localparam int DEPTH = (NUM_STAGES > 1) ? NUM_STAGES - 1 : 1;

    // Multiplier bit XLEN-1 carries weight -2^(XLEN-1) when rs2 is signed.
    function automatic logic [PW-1:0] add_chunk(input logic [PW-1:0] acc, input logic [PW-1:0] ea,
                                                 input logic [XLEN-1:0] b, input logic b_signed,
                                                 input int k);
        logic [PW-1:0] sum;
        sum = acc;
        for (int j = 0; j < CW; j++) begin
            int idx;
            idx = k * CW + j;
            if (b[idx]) begin
                if (b_signed && idx == XLEN - 1)
                    sum = sum - (ea << idx);
                else
                    sum = sum + (ea << idx);
            end
        end
        return sum;
    endfunction

    logic             a_signed_in;
    logic             b_signed_in;
    logic [PW-1:0]    in_ea;
    logic             stall;
    logic             load;
    logic             last_valid;
    logic             hold_valid;
    logic [1:0]       last_func;
    logic [TAG_W-1:0] last_tag;
    logic [PW-1:0]    last_acc;

    assign a_signed_in = (func != 2'b11);
    assign b_signed_in = ~func[1];
    assign in_ea       = {{XLEN{a_signed_in & opa[XLEN-1]}}, opa};

    assign stall = done & ~ack & hold_valid;
    assign ready = ~stall;
    assign load  = last_valid & ~stall & ~squash;

    generate
        if (NUM_STAGES > 1) begin : g_pipe
            logic             s_valid_reg [DEPTH];
            logic [1:0]       s_func_reg  [DEPTH];
            logic [TAG_W-1:0] s_tag_reg   [DEPTH];
            logic [PW-1:0]    s_ea_reg    [DEPTH];
            logic [XLEN-1:0]  s_b_reg     [DEPTH];
            logic [PW-1:0]    s_acc_reg   [DEPTH];
            logic             s_valid_next[DEPTH];
            logic [1:0]       s_func_next [DEPTH];
            logic [TAG_W-1:0] s_tag_next  [DEPTH];
            logic [PW-1:0]    s_ea_next   [DEPTH];
            logic [XLEN-1:0]  s_b_next    [DEPTH];
            logic [PW-1:0]    s_acc_next  [DEPTH];

            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    // Chunk 0 is accumulated in the issue cycle so the result lands after NUM_STAGES edges.
                    assign s_valid_next[gi] = issue_valid & ready;
                    assign s_func_next[gi]  = func;
                    assign s_tag_next[gi]   = rob_tag;
                    assign s_ea_next[gi]    = in_ea;
                    assign s_b_next[gi]     = opb;
                    assign s_acc_next[gi]   = add_chunk({PW{1'b0}}, in_ea, opb, b_signed_in, 0);
                end else begin : g_mid
                    assign s_valid_next[gi] = s_valid_reg[gi-1];
                    assign s_func_next[gi]  = s_func_reg[gi-1];
                    assign s_tag_next[gi]   = s_tag_reg[gi-1];
                    assign s_ea_next[gi]    = s_ea_reg[gi-1];
                    assign s_b_next[gi]     = s_b_reg[gi-1];
                    assign s_acc_next[gi]   = add_chunk(s_acc_reg[gi-1], s_ea_reg[gi-1], s_b_reg[gi-1],
                                                        ~s_func_reg[gi-1][1], gi);
                end
            end

            always_ff @(posedge clock) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (reset || squash)
                        s_valid_reg[i] <= 1'b0;
                    else if (!stall)
                        s_valid_reg[i] <= s_valid_next[i];
                    if (!stall) begin
                        s_func_reg[i] <= s_func_next[i];
                        s_tag_reg[i]  <= s_tag_next[i];
                        s_ea_reg[i]   <= s_ea_next[i];
                        s_b_reg[i]    <= s_b_next[i];
                        s_acc_reg[i]  <= s_acc_next[i];
                    end
                end
            end

            assign last_valid = s_valid_reg[DEPTH-1];
            assign hold_valid = last_valid;
            assign last_func  = s_func_reg[DEPTH-1];
            assign last_tag   = s_tag_reg[DEPTH-1];
            assign last_acc   = add_chunk(s_acc_reg[DEPTH-1], s_ea_reg[DEPTH-1], s_b_reg[DEPTH-1],
                                          ~s_func_reg[DEPTH-1][1], NUM_STAGES - 1);
        end else begin : g_single
            // Single stage: the issuing op is the last stage, so hold on any unacked result
            // to keep ready independent of issue_valid.
            assign last_valid = issue_valid;
            assign hold_valid = 1'b1;
            assign last_func  = func;
            assign last_tag   = rob_tag;
            assign last_acc   = add_chunk({PW{1'b0}}, in_ea, opb, b_signed_in, 0);
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            done        <= 1'b0;
            result      <= '0;
            out_rob_tag <= '0;
        end else if (squash) begin
            done <= 1'b0;
        end else if (load) begin
            done        <= 1'b1;
            result      <= (last_func == 2'b00) ? last_acc[XLEN-1:0] : last_acc[PW-1:XLEN];
            out_rob_tag <= last_tag;
        end else if (ack) begin
            done <= 1'b0;
        end
    end

`ifdef MULT_FU_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_completions  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (load && perf_completions != 32'hFFFF_FFFF)
                perf_completions <= perf_completions + 32'd1;
            if (stall && perf_stall_cycles != 32'hFFFF_FFFF)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_fu.sv
// Directed bench for mult_fu: scoreboard of expected {tag,result} checked on every accepted completion.
module tb_mult_fu;

    logic        clock = 1'b0;
    logic        reset, squash, issue_valid, ack;
    logic [1:0]  func;
    logic [31:0] opa, opb;
    logic [4:0]  rob_tag;
    logic        ready, done;
    logic [31:0] result;
    logic [4:0]  out_rob_tag;
`ifdef MULT_FU_PERF_CNT_EN
    logic [31:0] perf_completions, perf_stall_cycles;
`endif

    typedef struct packed {
        logic [4:0]  tag;
        logic [31:0] res;
    } sb_t;

    sb_t exp_q[$];
    sb_t mon_e;
    int  tests = 0;
    int  fails = 0;

    mult_fu dut (
        .clock(clock), .reset(reset), .squash(squash), .issue_valid(issue_valid),
        .func(func), .opa(opa), .opb(opb), .rob_tag(rob_tag), .ack(ack),
        .ready(ready), .done(done), .result(result), .out_rob_tag(out_rob_tag)
`ifdef MULT_FU_PERF_CNT_EN
        , .perf_completions(perf_completions), .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference: full-width product of the sign/zero-extended operands.
    function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (f == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
        eb = f[1] ? {32'b0, b} : {{32{b[31]}}, b};
        p  = ea * eb;
        return (f == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk32(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic chk1(input string name, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", name, obs, exp);
        end
    endtask

    // Present an op like the RS would: hold it until ready, then record the expectation.
    task automatic issue_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] tag, input logic [31:0] exp_res,
                            output logic rdy_first, output logic done_seen);
        issue_valid = 1'b1; func = f; opa = a; opb = b; rob_tag = tag;
        @(negedge clock);
        rdy_first = ready;
        done_seen = done;
        for (int w = 0; w < 20 && !ready; w++) begin
            @(posedge clock); #1;
            @(negedge clock);
        end
        chk1("issue_accept", ready, 1'b1);
        if (ready) exp_q.push_back({tag, exp_res});
        $display("[TB] issue tag=%0d func=%0d opa=%h opb=%h exp=%h", tag, f, a, b, exp_res);
        @(posedge clock); #1;
    endtask

    task automatic drain(input string name);
        for (int w = 0; w < 40 && exp_q.size() != 0; w++) begin
            @(posedge clock); #1;
        end
        chk32(name, 32'(exp_q.size()), 32'd0);
        @(posedge clock); #1;
    endtask

    always @(negedge clock) begin
        if (!reset && !squash && done && ack) begin
            tests++;
            assert (exp_q.size() > 0) else begin
                fails++;
                $error("FAIL sb_unexpected: observed tag %0d result %h expected none", out_rob_tag, result);
            end
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                tests++;
                assert ({out_rob_tag, result} === mon_e) else begin
                    fails++;
                    $error("FAIL sb_result: observed tag %0d result %h expected tag %0d result %h",
                           out_rob_tag, result, mon_e.tag, mon_e.res);
                end
                $display("[TB] complete tag=%0d result=%h", out_rob_tag, result);
            end
        end
    end

    initial begin
        logic [1:0]  f;
        logic [31:0] a, b, exp_a, exp_b;
        logic        r, d;

        reset = 1'b1; squash = 1'b0; issue_valid = 1'b0; ack = 1'b0;
        func = 2'b00; opa = '0; opb = '0; rob_tag = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk1("rst_ready", ready, 1'b1);
        chk1("rst_done", done, 1'b0);
        chk32("rst_result", result, 32'd0);
        chk32("rst_tag", 32'(out_rob_tag), 32'd0);

        // MUL 7 x -3 with latency check
        @(posedge clock); #1;
        ack = 1'b1;
        issue_op(2'b00, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, r, d);
        issue_valid = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk1("t1_latency_done", done, 1'b0);
            @(posedge clock); #1;
        end
        @(negedge clock);
        chk1("t1_done", done, 1'b1);
        chk32("t1_result", result, 32'hFFFF_FFEB);
        chk32("t1_tag", 32'(out_rob_tag), 32'd5);
        @(posedge clock); #1;
        @(negedge clock);
        chk1("t1_done_clear", done, 1'b0);
        chk32("t1_result_kept", result, 32'hFFFF_FFEB);
        @(posedge clock); #1;

        // High-half variants on all-ones operands
        issue_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, r, d);
        issue_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF, r, d);
        issue_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, r, d);
        issue_valid = 1'b0;
        drain("t2_drain");

        // Back-to-back six ops, ack held high
        for (int i = 0; i < 6; i++) begin
            f = 2'(i % 4); a = 32'h1234_0000 + 32'(i * 977); b = 32'hF000_0003 - 32'(i * 31);
            issue_op(f, a, b, 5'(10 + i), model(f, a, b), r, d);
            chk1("t3_ready", r, 1'b1);
            chk1("t3_done_during_issue", d, (i >= 4));
        end
        issue_valid = 1'b0;
        repeat (4) begin
            @(negedge clock);
            chk1("t3_done_run", done, 1'b1);
            @(posedge clock); #1;
        end
        @(negedge clock);
        chk1("t3_done_end", done, 1'b0);
        drain("t3_drain");

        // Backpressure: ack low for three cycles
        exp_a = model(2'b00, 32'd123456, 32'd789);
        exp_b = model(2'b11, 32'hDEAD_BEEF, 32'h1234_5678);
        issue_op(2'b00, 32'd123456, 32'd789, 5'd20, exp_a, r, d);
        issue_op(2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 5'd21, exp_b, r, d);
        issue_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, model(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), r, d);
        issue_op(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd23, model(2'b01, 32'h8000_0000, 32'h8000_0000), r, d);
        issue_valid = 1'b0;
        ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                issue_valid = 1'b1; func = 2'b00; opa = 32'd5; opb = 32'd5; rob_tag = 5'd31;
            end
            @(negedge clock);
            chk1("t4_stall_ready", ready, 1'b0);
            chk1("t4_stall_done", done, 1'b1);
            chk32("t4_stall_result", result, exp_a);
            @(posedge clock); #1;
            issue_valid = 1'b0;
        end
        ack = 1'b1;
        @(negedge clock);
        chk32("t4_ack_result", result, exp_a);
        @(posedge clock); #1;
        @(negedge clock);
        chk1("t4_next_done", done, 1'b1);
        chk32("t4_next_result", result, exp_b);
        chk32("t4_next_tag", 32'(out_rob_tag), 32'd21);
        drain("t4_drain");

        // Squash with done=1 and three ops in flight; ack and an issue in the same cycle lose
        for (int i = 0; i < 4; i++) begin
            a = 32'd1000 + 32'(i); b = 32'd3;
            issue_op(2'b00, a, b, 5'(24 + i), model(2'b00, a, b), r, d);
        end
        squash = 1'b1;
        func = 2'b00; opa = 32'd9; opb = 32'd9; rob_tag = 5'd30;
        @(negedge clock);
        chk1("t5_done_before_squash", done, 1'b1);
        @(posedge clock); #1;
        squash = 1'b0;
        exp_q.delete();
        issue_op(2'b11, 32'hCAFE_F00D, 32'h0BAD_BEEF, 5'd9, model(2'b11, 32'hCAFE_F00D, 32'h0BAD_BEEF), r, d);
        chk1("t5_done_cleared", d, 1'b0);
        chk1("t5_ready_after", r, 1'b1);
        issue_valid = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk1("t5_no_stale_done", done, 1'b0);
            @(posedge clock); #1;
        end
        @(negedge clock);
        chk1("t5_post_done", done, 1'b1);
        chk32("t5_post_tag", 32'(out_rob_tag), 32'd9);
        drain("t5_drain");

        // Random mix
        for (int i = 0; i < 12; i++) begin
            f = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
            issue_op(f, a, b, 5'(i + 8), model(f, a, b), r, d);
        end
        issue_valid = 1'b0;
        drain("rand_drain");

        // Reset mid-pipe with a stalled result
        for (int i = 0; i < 4; i++) begin
            a = 32'h7777_0000 + 32'(i); b = 32'h0000_0101;
            issue_op(2'b00, a, b, 5'(1 + i), model(2'b00, a, b), r, d);
        end
        issue_valid = 1'b0;
        ack = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        ack = 1'b1;
        exp_q.delete();
        @(negedge clock);
        chk1("t6_done", done, 1'b0);
        chk32("t6_result", result, 32'd0);
        chk32("t6_tag", 32'(out_rob_tag), 32'd0);
        chk1("t6_ready", ready, 1'b1);
`ifdef MULT_FU_PERF_CNT_EN
        chk32("t6_perf_completions", perf_completions, 32'd0);
        chk32("t6_perf_stalls", perf_stall_cycles, 32'd0);
`endif
        @(posedge clock); #1;
        repeat (5) begin
            @(negedge clock);
            chk1("t6_no_done", done, 1'b0);
            @(posedge clock); #1;
        end
        chk32("final_queue", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
